// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores to the data memory
// and forwards results to writeback through a valid/stall handshake.
module mem_access #(
    parameter int WORD = 32,
    parameter int ADDR = 16,
    parameter int W_RD = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            v_i,
    output logic            stall_o,
    input  logic            wb_i,
    input  logic [W_RD-1:0] rd_num_i,
    input  logic [1:0]      mop_i,
    input  logic [WORD-1:0] res_i,
    input  logic [WORD-1:0] st_data_i,
    output logic            v_o,
    input  logic            stall_i,
    output logic            wb_o,
    output logic [W_RD-1:0] rd_num_o,
    output logic [WORD-1:0] data_o,
    output logic [ADDR-1:0] dm_a_o,
    output logic            dm_w_o,
    output logic [WORD-1:0] dm_d_o,
    input  logic [WORD-1:0] dm_q_i
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LDWAIT = 2'd1,
        FULL   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            wb_q, wb_d;
    logic [W_RD-1:0] rd_q, rd_d;
    logic [WORD-1:0] data_q, data_d;

    logic accept;
    logic is_ld;
    logic is_st;

    // Decode the memory op; 2'b11 falls through as a plain ALU result.
    always_comb begin
        is_ld = (mop_i == 2'b01);
        is_st = (mop_i == 2'b10);
    end

    // Handshake: stall while the load data is in flight or WB holds us.
    always_comb begin
        stall_o = (state_q == LDWAIT) | ((state_q == FULL) & stall_i);
        accept  = v_i & ~stall_o;
    end

    // Memory port: address wraps to ADDR bits, write only on an accepted store.
    always_comb begin
        dm_a_o = res_i[ADDR-1:0];
        dm_w_o = accept & is_st;
        dm_d_o = st_data_i;
    end

    // Next-state and result capture.
    always_comb begin
        state_d = state_q;
        wb_d    = wb_q;
        rd_d    = rd_q;
        data_d  = data_q;
        unique case (state_q)
            LDWAIT: begin
                state_d = FULL;
                data_d  = dm_q_i;
            end
            EMPTY, FULL: begin
                if (accept) begin
                    state_d = is_ld ? LDWAIT : FULL;
                    rd_d    = rd_num_i;
                    wb_d    = wb_i & ~is_st;
                    if (!is_ld) begin
                        data_d = res_i;
                    end
                end else if (!((state_q == FULL) && stall_i)) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State and result registers; reset discards any held instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            wb_q    <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    // Registered outputs to writeback.
    always_comb begin
        v_o      = (state_q == FULL);
        wb_o     = wb_q;
        rd_num_o = rd_q;
        data_o   = data_q;
    end

endmodule
